// File: rtl/mem_share_ctrl_pkg.sv
// Shared definitions for the processor/loader memory-sharing controller:
// ownership state encoding, width defaults and small state-decode helpers.
package mem_share_ctrl_pkg;

  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 16;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [1:0] {
    ST_PROC    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Loader address/data stay on the bus through RELEASE so its last read completes.
  function automatic logic loader_drives_bus(input state_t s);
    return (s == ST_LOAD) || (s == ST_RELEASE);
  endfunction

  function automatic logic handover_busy(input state_t s);
    return (s == ST_DRAIN) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/mem_share_ctrl_mem_mux.sv
// 2:1 memory-port mux between processor and loader, with a global write gate
// so no write reaches memory while ownership is being handed back.
module mem_share_ctrl_mem_mux #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          sel_loader,
  input  logic          w_allow,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_dout,
  input  logic          p_w,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_dout,
  input  logic          l_w,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_dout,
  output logic          m_w
);

  assign m_addr = sel_loader ? l_addr : p_addr;
  assign m_dout = sel_loader ? l_dout : p_dout;
  assign m_w    = w_allow & (sel_loader ? l_w : p_w);

endmodule

// File: rtl/mem_share_ctrl.sv
// Arbitrates one single-port synchronous memory between the processor (default
// owner) and a loader; the processor is parked at T0 by gating Run before handover.
module mem_share_ctrl
  import mem_share_ctrl_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Run_in,
  output logic          Run,
  input  logic          P_Idle,
  input  logic [AW-1:0] P_ADDR,
  input  logic [DW-1:0] P_DOUT,
  input  logic          P_W,
  input  logic          L_Req,
  output logic          L_Gnt,
  input  logic [AW-1:0] L_ADDR,
  input  logic [DW-1:0] L_DOUT,
  input  logic          L_W,
  output logic          L_RdValid,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_DOUT,
  output logic          M_W,
  output logic          Busy
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST_QUIET = CW'(SETTLE - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] quiet_cnt, quiet_cnt_nxt;
  logic          quiet;
  logic          sel_loader;
  logic          w_allow;

  // A quiet cycle: processor sitting in T0 and not finishing a store.
  assign quiet = P_Idle & ~P_W;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= ST_PROC;
      quiet_cnt <= '0;
      L_RdValid <= 1'b0;
    end else begin
      state     <= state_nxt;
      quiet_cnt <= quiet_cnt_nxt;
      L_RdValid <= (state == ST_LOAD) & L_Req & ~L_W;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    quiet_cnt_nxt = '0;
    unique case (state)
      ST_PROC: begin
        if (L_Req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!L_Req) begin
          state_nxt = ST_PROC;
        end else if (quiet) begin
          if (quiet_cnt == LAST_QUIET) state_nxt = ST_LOAD;
          else                         quiet_cnt_nxt = quiet_cnt + CW'(1);
        end
      end
      ST_LOAD: begin
        if (!L_Req) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_nxt = ST_PROC;
      end
      default: state_nxt = ST_PROC;
    endcase
  end

  always_comb begin
    Run        = (state == ST_PROC) & Run_in;
    L_Gnt      = (state == ST_LOAD);
    Busy       = handover_busy(state);
    sel_loader = loader_drives_bus(state);
    w_allow    = (state != ST_RELEASE);
  end

  mem_share_ctrl_mem_mux #(
    .AW (AW),
    .DW (DW)
  ) u_mem_mux (
    .sel_loader (sel_loader),
    .w_allow    (w_allow),
    .p_addr     (P_ADDR),
    .p_dout     (P_DOUT),
    .p_w        (P_W),
    .l_addr     (L_ADDR),
    .l_dout     (L_DOUT),
    .l_w        (L_W),
    .m_addr     (M_ADDR),
    .m_dout     (M_DOUT),
    .m_w        (M_W)
  );

endmodule

// File: tb/tb_mem_share_ctrl.sv
// Self-checking bench for mem_share_ctrl: directed handover scenarios followed by
// randomized traffic, all compared against an ownership-level reference model.
module tb_mem_share_ctrl;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int SETTLE = 2;

  logic          Clock;
  logic          Resetn;
  logic          Run_in;
  logic          Run;
  logic          P_Idle;
  logic [AW-1:0] P_ADDR;
  logic [DW-1:0] P_DOUT;
  logic          P_W;
  logic          L_Req;
  logic          L_Gnt;
  logic [AW-1:0] L_ADDR;
  logic [DW-1:0] L_DOUT;
  logic          L_W;
  logic          L_RdValid;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_DOUT;
  logic          M_W;
  logic          Busy;

  int n_asserts = 0;
  int n_fail    = 0;

  mem_share_ctrl #(.AW(AW), .DW(DW), .SETTLE(SETTLE)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Run_in    (Run_in),
    .Run       (Run),
    .P_Idle    (P_Idle),
    .P_ADDR    (P_ADDR),
    .P_DOUT    (P_DOUT),
    .P_W       (P_W),
    .L_Req     (L_Req),
    .L_Gnt     (L_Gnt),
    .L_ADDR    (L_ADDR),
    .L_DOUT    (L_DOUT),
    .L_W       (L_W),
    .L_RdValid (L_RdValid),
    .M_ADDR    (M_ADDR),
    .M_DOUT    (M_DOUT),
    .M_W       (M_W),
    .Busy      (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Single-port synchronous memory with one-cycle read latency.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] mem_rdata;
  always @(posedge Clock) begin
    if (M_W) mem[M_ADDR[7:0]] <= M_DOUT;
    mem_rdata <= mem[M_ADDR[7:0]];
  end

  // Reference model: who owns the memory, and how many consecutive quiet
  // cycles the processor has shown since the loader asked.
  typedef enum {OWN_PROC, WAIT_QUIET, OWN_LOADER, HAND_BACK} owner_t;
  owner_t own    = OWN_PROC;
  int     quiet_seen = 0;
  bit     rd_pending = 1'b0;

  task automatic model_edge();
    owner_t nxt = own;
    if (!Resetn) begin
      own        = OWN_PROC;
      quiet_seen = 0;
      rd_pending = 1'b0;
      return;
    end
    rd_pending = (own == OWN_LOADER) && L_Req && !L_W;
    case (own)
      OWN_PROC:   if (L_Req) begin nxt = WAIT_QUIET; quiet_seen = 0; end
      WAIT_QUIET: begin
        if (!L_Req) nxt = OWN_PROC;
        else if (P_Idle && !P_W) begin
          quiet_seen++;
          if (quiet_seen >= SETTLE) nxt = OWN_LOADER;
        end else quiet_seen = 0;
      end
      OWN_LOADER: if (!L_Req) nxt = HAND_BACK;
      HAND_BACK:  nxt = OWN_PROC;
      default:    nxt = OWN_PROC;
    endcase
    own = nxt;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic          loader_bus = (own == OWN_LOADER) || (own == HAND_BACK);
    logic          exp_run    = (own == OWN_PROC) && Run_in;
    logic          exp_w      = (own == OWN_LOADER) ? L_W : (own == HAND_BACK) ? 1'b0 : P_W;
    logic [AW-1:0] exp_addr   = loader_bus ? L_ADDR : P_ADDR;
    logic [DW-1:0] exp_dout   = loader_bus ? L_DOUT : P_DOUT;
    check("run",      32'(Run),       32'(exp_run));
    check("l_gnt",    32'(L_Gnt),     32'(own == OWN_LOADER));
    check("busy",     32'(Busy),      32'((own == WAIT_QUIET) || (own == HAND_BACK)));
    check("rd_valid", 32'(L_RdValid), 32'(rd_pending));
    check("m_w",      32'(M_W),       32'(exp_w));
    check("m_addr",   32'(M_ADDR),    32'(exp_addr));
    check("m_dout",   32'(M_DOUT),    32'(exp_dout));
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wait_grant(input string tag, input int bound, output int cycles);
    cycles = 0;
    while (!L_Gnt && cycles < bound) begin
      step();
      cycles++;
    end
    if (!L_Gnt) check({tag, "_timeout"}, 32'(L_Gnt), 32'd1);
  endtask

  int lat;

  initial begin
    Resetn = 1'b0; Run_in = 1'b1; P_Idle = 1'b0; P_ADDR = 16'h0005; P_DOUT = 16'h0;
    P_W = 1'b0; L_Req = 1'b0; L_ADDR = 16'h0; L_DOUT = 16'h0; L_W = 1'b0;

    // Reset, processor owns memory
    step();
    step();
    Resetn = 1'b1;
    step();
    check("t1_run",    32'(Run),    32'd1);
    check("t1_m_addr", 32'(M_ADDR), 32'h0005);
    check("t1_l_gnt",  32'(L_Gnt),  32'd0);

    // Loader request while processor still storing, then quiet
    L_Req = 1'b1; P_Idle = 1'b0; P_W = 1'b1; P_DOUT = 16'h1234; P_ADDR = 16'h0020;
    repeat (3) step();
    check("t2_m_w_follows_p", 32'(M_W), 32'd1);
    check("t2_run_low",       32'(Run), 32'd0);
    P_Idle = 1'b1; P_W = 1'b0;
    wait_grant("t2_grant", 10, lat);
    check("t2_grant_latency", 32'(lat), 32'(SETTLE));

    // Loader write then read back through the memory
    L_ADDR = 16'h0010; L_DOUT = 16'hBEEF; L_W = 1'b1;
    #1;
    check_all();
    check("t3_m_w",    32'(M_W),    32'd1);
    check("t3_m_dout", 32'(M_DOUT), 32'hBEEF);
    step();
    L_W = 1'b0; L_DOUT = 16'h0000;
    step();
    check("t3_rd_valid", 32'(L_RdValid), 32'd1);
    check("t3_rd_data",  32'(mem_rdata), 32'hBEEF);

    // Loader lets go: one RELEASE cycle, then processor again
    L_Req = 1'b0;
    step();
    check("t4_busy",    32'(Busy), 32'd1);
    P_ADDR = 16'h0077; L_W = 1'b1; Run_in = 1'b1;
    #1;
    check("t4_m_w_gated", 32'(M_W), 32'd0);
    check_all();
    L_W = 1'b0;
    step();
    check("t4_run",    32'(Run),    32'd1);
    check("t4_m_addr", 32'(M_ADDR), 32'h0077);

    // Short request pulse during DRAIN never grants
    L_Req = 1'b1; P_Idle = 1'b0;
    step();
    L_Req = 1'b0;
    step();
    check("t5_l_gnt", 32'(L_Gnt), 32'd0);
    step();
    check("t5_run",   32'(Run),   32'd1);

    // Reset while loader owns memory and is writing
    L_Req = 1'b1; P_Idle = 1'b1; P_W = 1'b0;
    wait_grant("t6_grant", 10, lat);
    L_W = 1'b1; L_ADDR = 16'h0033; Resetn = 1'b0; P_W = 1'b1;
    step();
    check("t6_l_gnt", 32'(L_Gnt), 32'd0);
    check("t6_m_w",   32'(M_W),   32'd1);
    check("t6_busy",  32'(Busy),  32'd0);
    Resetn = 1'b1; L_Req = 1'b0; L_W = 1'b0; P_W = 1'b0;
    step();

    // Randomized sessions
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) L_Req = ~L_Req;
      Run_in = ($urandom_range(0, 3) != 0);
      P_Idle = ($urandom_range(0, 9) < 7);
      P_W    = ($urandom_range(0, 3) == 0);
      P_ADDR = 16'($urandom);
      P_DOUT = 16'($urandom);
      L_ADDR = 16'($urandom);
      L_DOUT = 16'($urandom);
      L_W    = 1'($urandom_range(0, 1));
      Resetn = ($urandom_range(0, 199) != 0);
      #1;
      check_all();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
